// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, word/state types and round helper functions.
// Working state is stored with a/H0 in the top word so it casts directly to/from 256-bit buses.
package sha256_pkg;
  localparam int BLOCK_W = 512;
  localparam int HASH_W  = 256;
  localparam int WORD_W  = 32;
  localparam int ROUNDS  = 64;
  localparam int LATENCY = ROUNDS + 1;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [7:0]  state_t;  // [7]=a ... [0]=h
  typedef word_t [15:0] sched_t;  // [15]=W[t] ... [0]=W[t+15]

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t big_sigma0(input word_t x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
endpackage

// File: rtl/sha256_if.sv
// Block-in / hash-out bus of the SHA-256 compression pipeline.
interface sha256_if;
  import sha256_pkg::*;

  logic [BLOCK_W-1:0] block;
  logic               block_valid;
  logic [HASH_W-1:0]  prev_hash;
  logic [HASH_W-1:0]  hash;
  logic               hash_valid;

  modport master (output block, output block_valid, output prev_hash,
                  input hash, input hash_valid);
  modport slave  (input block, input block_valid, input prev_hash,
                  output hash, output hash_valid);
endinterface

// File: rtl/sha256_round.sv
// One registered SHA-256 round; the schedule window slides by one word so every stage is identical.
module sha256_round
  import sha256_pkg::*;
#(
  parameter int unsigned T = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  state_t in_state,
  input  sched_t in_sched,
  input  state_t in_prev,
  output logic   out_valid,
  output state_t out_state,
  output sched_t out_sched,
  output state_t out_prev
);
  localparam logic [5:0] IDX = T[5:0];

  word_t t1;
  word_t t2;
  word_t w_next;

  // Window holds W[t..t+15]; the word appended is W[t+16].
  always_comb begin
    t1     = in_state[0] + big_sigma1(in_state[3]) + ch(in_state[3], in_state[2], in_state[1])
           + K[IDX] + in_sched[15];
    t2     = big_sigma0(in_state[7]) + maj(in_state[7], in_state[6], in_state[5]);
    w_next = small_sigma1(in_sched[1]) + in_sched[6] + small_sigma0(in_sched[14]) + in_sched[15];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_state <= '0;
      out_sched <= '0;
      out_prev  <= '0;
    end else begin
      out_valid <= in_valid;
      out_state <= {t1 + t2, in_state[7:5], in_state[4] + t1, in_state[3:1]};
      out_sched <= {in_sched[14:0], w_next};
      out_prev  <= in_prev;
    end
  end
endmodule

// File: rtl/sha256_pipeline.sv
// Fully pipelined SHA-256 compression: input register, 64 round stages, final chaining addition.
module sha256_pipeline
  import sha256_pkg::*;
(
  input logic     clk,
  input logic     rst_n,
  sha256_if.slave bus
);
  logic   in_valid_q;
  sched_t in_sched_q;
  state_t in_prev_q;

  logic   v_pipe  [ROUNDS+1];
  state_t st_pipe [ROUNDS+1];
  sched_t w_pipe  [ROUNDS+1];
  state_t ph_pipe [ROUNDS+1];
  state_t sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      in_sched_q <= '0;
      in_prev_q  <= '0;
    end else begin
      in_valid_q <= bus.block_valid;
      in_sched_q <= bus.block;
      in_prev_q  <= bus.prev_hash;
    end
  end

  // Round 0 starts from the block's own chaining value.
  assign v_pipe[0]  = in_valid_q;
  assign st_pipe[0] = in_prev_q;
  assign w_pipe[0]  = in_sched_q;
  assign ph_pipe[0] = in_prev_q;

  for (genvar t = 0; t < ROUNDS; t++) begin : g_round
    sha256_round #(.T(t)) u_round (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (v_pipe[t]),
      .in_state (st_pipe[t]),
      .in_sched (w_pipe[t]),
      .in_prev  (ph_pipe[t]),
      .out_valid(v_pipe[t+1]),
      .out_state(st_pipe[t+1]),
      .out_sched(w_pipe[t+1]),
      .out_prev (ph_pipe[t+1])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) sum[i] = st_pipe[ROUNDS][i] + ph_pipe[ROUNDS][i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hash       <= '0;
      bus.hash_valid <= 1'b0;
    end else begin
      bus.hash       <= sum;
      bus.hash_valid <= v_pipe[ROUNDS];
    end
  end
endmodule

// File: tb/tb_sha256_pipeline.sv
// Scoreboard bench for sha256_pipeline against a straightforward software compression model.
module tb_sha256_pipeline;
  import sha256_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_if bus ();
  sha256_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [255:0] h;
    int           due;
  } exp_t;

  exp_t q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'b0};
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'b0, 32'h00000018};
  localparam logic [255:0] EMPTY_H   = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] ABC_H     = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] model(input logic [511:0] b, input logic [255:0] ph);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) begin
      hv[i] = ph[255 - 32*i -: 32];
      v[i]  = hv[i];
    end
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[i] + v[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] rb;
    for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom();
    return rb;
  endfunction

  function automatic logic [255:0] rand_hash();
    logic [255:0] rh;
    for (int i = 0; i < 8; i++) rh[32*i +: 32] = $urandom();
    return rh;
  endfunction

  // Block sampled at the next rising edge is due 65 edges after that.
  task automatic drive(input logic v, input logic [511:0] b, input logic [255:0] ph,
                       input logic [255:0] e);
    @(negedge clk);
    bus.block_valid = v;
    bus.block       = b;
    bus.prev_hash   = ph;
    if (v) q.push_back('{h: e, due: cyc + 1 + LATENCY});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rand_block(), rand_hash(), '0);
  endtask

  always @(negedge clk) begin
    logic ev;
    exp_t e;
    ev = (q.size() > 0) && (q[0].due == cyc);
    checks++;
    if (bus.hash_valid !== ev) begin
      errors++;
      $display("FAIL valid_pattern cyc=%0d got=%b expected=%b", cyc, bus.hash_valid, ev);
    end
    if (ev) begin
      e = q.pop_front();
      checks++;
      if (bus.hash !== e.h) begin
        errors++;
        $display("FAIL hash cyc=%0d got=%h expected=%h", cyc, bus.hash, e.h);
      end
    end
  end

  initial begin
    logic [15:0] pat;
    logic [511:0] b;
    logic [255:0] ph;
    rst_n           = 1'b0;
    bus.block_valid = 1'b0;
    bus.block       = '0;
    bus.prev_hash   = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.hash !== 256'b0) begin
      errors++;
      $display("FAIL reset_hash got=%h expected=0", bus.hash);
    end
    #2 rst_n = 1'b1;

    // Known-answer vectors, single pulses
    drive(1'b1, EMPTY_BLK, IV, EMPTY_H);
    idle(70);
    drive(1'b1, ABC_BLK, IV, ABC_H);
    idle(70);

    // Eight back-to-back random blocks
    for (int i = 0; i < 8; i++) begin
      b  = rand_block();
      ph = rand_hash();
      drive(1'b1, b, ph, model(b, ph));
    end
    idle(70);

    // Gapped pattern mixing the two known blocks with varied chaining values
    pat = 16'b1011_0010_1110_0101;
    for (int i = 0; i < 16; i++) begin
      b  = (i % 3 == 0) ? EMPTY_BLK : ABC_BLK;
      ph = (i % 5 == 0) ? IV : rand_hash();
      drive(pat[i], b, ph, model(b, ph));
    end
    idle(70);

    // Continuous stream so hash_valid is high when reset hits
    for (int i = 0; i < 80; i++) begin
      b  = rand_block();
      ph = rand_hash();
      drive(1'b1, b, ph, model(b, ph));
    end
    @(negedge clk);
    bus.block_valid = 1'b0;
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if (bus.hash_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_valid got=%b expected=0", bus.hash_valid);
    end
    checks++;
    if (bus.hash !== 256'b0) begin
      errors++;
      $display("FAIL reset_async_hash got=%h expected=0", bus.hash);
    end
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    b  = rand_block();
    ph = rand_hash();
    drive(1'b1, b, ph, model(b, ph));

    // Idle with random data on the bus
    idle(200);
    idle(70);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
